// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the async FIFO: pops bytes under a 2-entry credit limit and
// re-presents them as a valid/ready byte stream with a per-packet last marker.
module fifo_stream_reader #(
  parameter int DATA_W    = 8,
  parameter int PKT_LEN   = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_out,
  input  logic              fifo_empty,
  input  logic              fifo_almost_empty,
  output logic              fifo_r_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       byte_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a byte transfers on every rising edge where m_valid & m_ready; once
  // m_valid rises, m_data/m_last hold until that transfer happens.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  localparam logic [1:0]  DEPTH_C  = 2'(BUF_DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic              head_q, tail_q;
  logic [1:0]        cnt_q;
  logic              inflight_q;
  logic [15:0]       pkt_idx_q;
  logic [15:0]       byte_cnt_q;

  logic       pop;
  logic [1:0] occ_free;
  logic       fetch_ok;
  logic       rd_en;

  assign m_valid   = (cnt_q != 2'd0);
  assign m_data    = mem_q[head_q];
  assign m_last    = m_valid & (pkt_idx_q == LAST_IDX);
  assign byte_cnt  = byte_cnt_q;
  assign dbg_state = state_q;
  assign fifo_r_en = rd_en;

  assign pop = m_valid & m_ready;
  // A pop in this cycle frees a slot in time for a read issued in this cycle.
  assign occ_free = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign fetch_ok = enable & ~fifo_empty & (occ_free < DEPTH_C);

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_ok) state_d = S_READ;
      end
      S_READ: begin
        // Gated live so enable, empty and credit take effect in the same cycle.
        rd_en = fetch_ok;
        if (fifo_almost_empty) state_d = S_GUARD;
        else if (!fetch_ok)    state_d = S_IDLE;
      end
      S_GUARD: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      pkt_idx_q  <= 16'd0;
      byte_cnt_q <= 16'd0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      cnt_q      <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      if (inflight_q) begin
        mem_q[tail_q] <= fifo_out;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q     <= ~head_q;
        byte_cnt_q <= byte_cnt_q + 16'd1;
        pkt_idx_q  <= (pkt_idx_q == LAST_IDX) ? 16'd0 : pkt_idx_q + 16'd1;
      end
    end
  end

endmodule
